pwm_generator: RTL and testbench

- Parametric PWM generator sitting directly downstream of the prescaler.
- Consumes the prescaler's one-cycle tick strobe as a count enable. One PWM period is 2^SIZE ticks, so the PWM frequency equals the prescaler's FREC_OUT when SIZE matches.
- Provides a glitch-free duty update: a shadowed duty register is applied only at the period boundary. Also provides a controlled start/stop that always completes the current period.

---
 rtl/pwm_generator.sv | 52 +++++
 tb/tb_pwm_generator.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/pwm_generator.sv
// pwm_generator: tick-driven PWM with boundary-shadowed duty and stop-at-period-end control
module pwm_generator #(
  parameter int SIZE = 8
) (
  input  logic            clkMhz,
  input  logic            rst,
  input  logic            tick,
  input  logic            en,
  input  logic [SIZE-1:0] duty,
  input  logic            duty_load,
  input  logic            polarity,
  output logic            pwm,
  output logic            period_end,
  output logic            load_ack,
  output logic            busy
);
  typedef enum logic [1:0] {IDLE, RUN, STOP_PEND} state_t;
  state_t          state, nxt;
  logic [SIZE-1:0] cnt, active_duty, pend_duty;
  logic            pend_valid, wrap, apply;
  always_comb begin
    wrap  = (state != IDLE) && tick && (cnt == {SIZE{1'b1}});
    apply = pend_valid && (wrap || (state == IDLE && en));
    nxt   = state == IDLE ? (en ? RUN : IDLE) :
            state == RUN  ? (en ? RUN : STOP_PEND) :
                            (en ? RUN : (wrap ? IDLE : STOP_PEND));
  end
  // a load in the same cycle as an apply wins the pending slot for the next boundary
  always_ff @(posedge clkMhz or negedge rst) begin
    if (!rst) begin
      state       <= IDLE;
      cnt         <= '0;
      active_duty <= '0;
      pend_duty   <= '0;
      pend_valid  <= 1'b0;
      pwm         <= 1'b0;
      period_end  <= 1'b0;
      load_ack    <= 1'b0;
      busy        <= 1'b0;
    end else begin
      state       <= nxt;
      busy        <= nxt != IDLE;
      cnt         <= state == IDLE ? '0 : cnt + SIZE'(tick);
      period_end  <= wrap;
      load_ack    <= apply;
      active_duty <= apply ? pend_duty : active_duty;
      pend_duty   <= duty_load ? duty : pend_duty;
      pend_valid  <= duty_load | (pend_valid & ~apply);
      pwm         <= state == IDLE ? polarity : ((cnt < active_duty) ^ polarity);
    end
  end
endmodule

// File: tb/tb_pwm_generator.sv
// tb_pwm_generator: directed scenarios for pwm_generator at SIZE=4 with a tick every 3 clocks
module tb_pwm_generator;
  localparam int SIZE = 4;
  logic clkMhz = 1'b0, rst, tick, en, duty_load, polarity;
  logic [SIZE-1:0] duty;
  logic pwm, period_end, load_ack, busy;
  int errors = 0, checks = 0, phase = 0;
  int n, hi, acks, blo;

  pwm_generator #(.SIZE(SIZE)) dut (
    .clkMhz(clkMhz), .rst(rst), .tick(tick), .en(en), .duty(duty),
    .duty_load(duty_load), .polarity(polarity), .pwm(pwm),
    .period_end(period_end), .load_ack(load_ack), .busy(busy)
  );

  always #5 clkMhz = ~clkMhz;

  task automatic cyc();
    tick = (phase == 0);
    @(posedge clkMhz);
    #1;
    duty_load = 1'b0;
    phase = (phase + 1) % 3;
  endtask

  // runs until a period_end sample (or 100 cycles) counting samples, pwm-high samples, acks and busy-low samples
  task automatic run_win(input int l1, l1v, l2, l2v, e1, e1v, e2, e2v,
                         output int wn, whi, wacks, wblo);
    wn = 0; whi = 0; wacks = 0; wblo = 0;
    do begin
      cyc();
      wn++;
      whi += int'(pwm);
      wacks += int'(load_ack);
      wblo += int'(!busy);
      if (wn == l1) begin duty = SIZE'(l1v); duty_load = 1'b1; end
      if (wn == l2) begin duty = SIZE'(l2v); duty_load = 1'b1; end
      if (wn == e1) en = e1v[0];
      if (wn == e2) en = e2v[0];
    end while (!period_end && wn < 100);
  endtask

  task automatic test_reset();
    cyc(); cyc();
    checks += 4;
    if (pwm !== 1'b0) begin errors++; $display("FAIL reset_pwm got=%b exp=0", pwm); end
    if (period_end !== 1'b0) begin errors++; $display("FAIL reset_pe got=%b exp=0", period_end); end
    if (load_ack !== 1'b0) begin errors++; $display("FAIL reset_ack got=%b exp=0", load_ack); end
    if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", busy); end
    rst = 1'b1;
    cyc();
  endtask

  task automatic test_start();
    duty = 4'd4; duty_load = 1'b1;
    cyc();
    checks += 2;
    if (load_ack !== 1'b0) begin errors++; $display("FAIL idle_load_ack got=%b exp=0", load_ack); end
    if (busy !== 1'b0) begin errors++; $display("FAIL idle_busy got=%b exp=0", busy); end
    en = 1'b1;
    cyc();
    checks += 2;
    if (busy !== 1'b1) begin errors++; $display("FAIL start_busy got=%b exp=1", busy); end
    if (load_ack !== 1'b1) begin errors++; $display("FAIL start_ack got=%b exp=1", load_ack); end
    cyc();
    checks++;
    if (load_ack !== 1'b0) begin errors++; $display("FAIL start_ack_pulse got=%b exp=0", load_ack); end
    run_win(-1, 0, -1, 0, -1, 0, -1, 0, n, hi, acks, blo);
    checks++;
    if (n < 1 || n > 48) begin errors++; $display("FAIL start_first_period got=%0d exp=1..48", n); end
    run_win(-1, 0, -1, 0, -1, 0, -1, 0, n, hi, acks, blo);
    checks += 3;
    if (n !== 48) begin errors++; $display("FAIL d4_period got=%0d exp=48", n); end
    if (hi !== 12) begin errors++; $display("FAIL d4_high got=%0d exp=12", hi); end
    if (acks !== 0) begin errors++; $display("FAIL d4_acks got=%0d exp=0", acks); end
  endtask

  task automatic test_midload();
    run_win(22, 10, -1, 0, -1, 0, -1, 0, n, hi, acks, blo);
    checks += 3;
    if (hi !== 12) begin errors++; $display("FAIL mid_keep_high got=%0d exp=12", hi); end
    if (acks !== 1) begin errors++; $display("FAIL mid_acks got=%0d exp=1", acks); end
    if (load_ack !== 1'b1) begin errors++; $display("FAIL mid_ack_at_wrap got=%b exp=1", load_ack); end
    run_win(-1, 0, -1, 0, -1, 0, -1, 0, n, hi, acks, blo);
    checks += 2;
    if (hi !== 30) begin errors++; $display("FAIL d10_high got=%0d exp=30", hi); end
    if (n !== 48) begin errors++; $display("FAIL d10_period got=%0d exp=48", n); end
  endtask

  task automatic test_double_load();
    run_win(5, 6, 30, 9, -1, 0, -1, 0, n, hi, acks, blo);
    checks += 2;
    if (hi !== 30) begin errors++; $display("FAIL dbl_keep_high got=%0d exp=30", hi); end
    if (acks !== 1) begin errors++; $display("FAIL dbl_acks got=%0d exp=1", acks); end
    run_win(-1, 0, -1, 0, -1, 0, -1, 0, n, hi, acks, blo);
    checks += 2;
    if (hi !== 27) begin errors++; $display("FAIL dbl_last_wins got=%0d exp=27", hi); end
    if (acks !== 0) begin errors++; $display("FAIL dbl_no_extra_ack got=%0d exp=0", acks); end
  endtask

  task automatic test_stop();
    int pes, his, bs;
    run_win(-1, 0, -1, 0, 15, 0, -1, 0, n, hi, acks, blo);
    checks += 4;
    if (n !== 48) begin errors++; $display("FAIL stop_full_period got=%0d exp=48", n); end
    if (hi !== 27) begin errors++; $display("FAIL stop_high got=%0d exp=27", hi); end
    if (blo !== 1) begin errors++; $display("FAIL stop_busy_low_samples got=%0d exp=1", blo); end
    if (busy !== 1'b0) begin errors++; $display("FAIL stop_busy_at_wrap got=%b exp=0", busy); end
    pes = 0; his = 0; bs = 0;
    for (int i = 0; i < 60; i++) begin
      cyc();
      pes += int'(period_end); his += int'(pwm); bs += int'(busy);
    end
    checks += 3;
    if (pes !== 0) begin errors++; $display("FAIL idle_period_end got=%0d exp=0", pes); end
    if (his !== 0) begin errors++; $display("FAIL idle_pwm got=%0d exp=0", his); end
    if (bs !== 0) begin errors++; $display("FAIL idle_busy_count got=%0d exp=0", bs); end
  endtask

  task automatic test_resume();
    en = 1'b1;
    cyc();
    checks += 2;
    if (busy !== 1'b1) begin errors++; $display("FAIL restart_busy got=%b exp=1", busy); end
    if (load_ack !== 1'b0) begin errors++; $display("FAIL restart_ack got=%b exp=0", load_ack); end
    run_win(-1, 0, -1, 0, -1, 0, -1, 0, n, hi, acks, blo);
    run_win(-1, 0, -1, 0, 15, 0, 36, 1, n, hi, acks, blo);
    checks += 3;
    if (n !== 48) begin errors++; $display("FAIL resume_period got=%0d exp=48", n); end
    if (hi !== 27) begin errors++; $display("FAIL resume_high got=%0d exp=27", hi); end
    if (blo !== 0) begin errors++; $display("FAIL resume_busy_low got=%0d exp=0", blo); end
    run_win(-1, 0, -1, 0, -1, 0, -1, 0, n, hi, acks, blo);
    checks += 2;
    if (n !== 48) begin errors++; $display("FAIL resume_next_period got=%0d exp=48", n); end
    if (hi !== 27) begin errors++; $display("FAIL resume_next_high got=%0d exp=27", hi); end
  endtask

  task automatic test_polarity();
    polarity = 1'b1;
    run_win(1, 0, -1, 0, -1, 0, -1, 0, n, hi, acks, blo);
    checks += 2;
    if (hi !== 21) begin errors++; $display("FAIL pol_d9_high got=%0d exp=21", hi); end
    if (acks !== 1) begin errors++; $display("FAIL pol_acks got=%0d exp=1", acks); end
    run_win(1, 15, -1, 0, -1, 0, -1, 0, n, hi, acks, blo);
    checks++;
    if (hi !== 48) begin errors++; $display("FAIL pol_d0_const got=%0d exp=48", hi); end
    run_win(-1, 0, -1, 0, -1, 0, -1, 0, n, hi, acks, blo);
    checks += 2;
    if (hi !== 3) begin errors++; $display("FAIL pol_d15_high got=%0d exp=3", hi); end
    if (n !== 48) begin errors++; $display("FAIL pol_d15_period got=%0d exp=48", n); end
  endtask

  task automatic test_reset_mid();
    polarity = 1'b0;
    for (int i = 1; i <= 27; i++) begin
      cyc();
      if (i == 5) begin duty = 4'd12; duty_load = 1'b1; end
    end
    checks += 2;
    if (pwm !== 1'b1) begin errors++; $display("FAIL pre_rst_pwm got=%b exp=1", pwm); end
    if (busy !== 1'b1) begin errors++; $display("FAIL pre_rst_busy got=%b exp=1", busy); end
    rst = 1'b0;
    #2;
    checks += 4;
    if (pwm !== 1'b0) begin errors++; $display("FAIL rst_mid_pwm got=%b exp=0", pwm); end
    if (busy !== 1'b0) begin errors++; $display("FAIL rst_mid_busy got=%b exp=0", busy); end
    if (period_end !== 1'b0) begin errors++; $display("FAIL rst_mid_pe got=%b exp=0", period_end); end
    if (load_ack !== 1'b0) begin errors++; $display("FAIL rst_mid_ack got=%b exp=0", load_ack); end
    cyc(); cyc();
    rst = 1'b1;
    cyc();
    checks += 2;
    if (busy !== 1'b1) begin errors++; $display("FAIL post_rst_busy got=%b exp=1", busy); end
    if (load_ack !== 1'b0) begin errors++; $display("FAIL post_rst_ack got=%b exp=0", load_ack); end
    run_win(-1, 0, -1, 0, -1, 0, -1, 0, n, hi, acks, blo);
    run_win(-1, 0, -1, 0, -1, 0, -1, 0, n, hi, acks, blo);
    checks += 3;
    if (n !== 48) begin errors++; $display("FAIL post_rst_period got=%0d exp=48", n); end
    if (hi !== 0) begin errors++; $display("FAIL post_rst_pwm got=%0d exp=0", hi); end
    if (acks !== 0) begin errors++; $display("FAIL post_rst_acks got=%0d exp=0", acks); end
  endtask

  initial begin
    rst = 1'b0; en = 1'b0; duty = '0; duty_load = 1'b0; polarity = 1'b0; tick = 1'b0;
    test_reset();
    test_start();
    test_midload();
    test_double_load();
    test_stop();
    test_resume();
    test_polarity();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
